// File: rtl/mips_pkg.sv
// Shared constants, state encoding and per-state control table
// for the MIPS multi-cycle control path.
package mips_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [3:0] ALUC_AND = 4'b0000;
  localparam logic [3:0] ALUC_OR  = 4'b0001;
  localparam logic [3:0] ALUC_ADD = 4'b0010;
  localparam logic [3:0] ALUC_SUB = 4'b0110;
  localparam logic [3:0] ALUC_SLT = 4'b0111;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_4    = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU = 2'b00;
  localparam logic [1:0] PCSRC_OUT = 2'b01;
  localparam logic [1:0] PCSRC_JMP = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_WB_R,
    S_EXEC_I, S_WB_I, S_ADDR, S_MEM_RD,
    S_WB_MEM, S_MEM_WR, S_BRANCH, S_JUMP,
    S_TRAP
  } state_t;

  // Moore part of the outputs; Mealy terms are added in the top.
  typedef struct packed {
    logic       memreq;
    logic       memwrite;
    logic       iord;
    logic [1:0] pcsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       sext;
    logic [3:0] aluc;
    logic       regrt;
    logic       mem2reg;
    logic       writereg;
    logic       done;
    logic       illegal;
  } ctrl_t;

  function automatic ctrl_t ctrl_of(state_t s, logic [3:0] fn_aluc);
    ctrl_t c;
    c      = '0;
    c.aluc = ALUC_ADD;
    case (s)
      S_FETCH: begin
        c.memreq  = 1'b1;
        c.alusrcb = SRCB_4;
      end
      S_DECODE: begin
        c.alusrcb = SRCB_IMM2;
        c.sext    = 1'b1;
      end
      S_EXEC_R: begin
        c.alusrca = 1'b1;
        c.alusrcb = SRCB_B;
        c.aluc    = fn_aluc;
      end
      S_WB_R: begin
        c.writereg = 1'b1;
        c.done     = 1'b1;
      end
      S_EXEC_I, S_ADDR: begin
        c.alusrca = 1'b1;
        c.alusrcb = SRCB_IMM;
        c.sext    = 1'b1;
      end
      S_WB_I: begin
        c.regrt    = 1'b1;
        c.writereg = 1'b1;
        c.done     = 1'b1;
      end
      S_MEM_RD: begin
        c.memreq = 1'b1;
        c.iord   = 1'b1;
      end
      S_WB_MEM: begin
        c.regrt    = 1'b1;
        c.mem2reg  = 1'b1;
        c.writereg = 1'b1;
        c.done     = 1'b1;
      end
      S_MEM_WR: begin
        c.memreq   = 1'b1;
        c.memwrite = 1'b1;
        c.iord     = 1'b1;
      end
      S_BRANCH: begin
        c.alusrca = 1'b1;
        c.alusrcb = SRCB_B;
        c.aluc    = ALUC_SUB;
        c.pcsrc   = PCSRC_OUT;
        c.done    = 1'b1;
      end
      S_JUMP: begin
        c.pcsrc = PCSRC_JMP;
        c.done  = 1'b1;
      end
      S_TRAP: c.illegal = 1'b1;
      default: c.illegal = 1'b0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// R-type funct decode to ALU control; flags unsupported funct codes.
// Shared with the single-cycle control unit.
module alu_decoder
  import mips_pkg::*;
(
  input  logic [5:0] i_func,
  output logic [3:0] o_aluc,
  output logic       o_illegal_func
);

  // Map funct to ALU operation; anything unknown is illegal.
  always_comb begin
    o_aluc         = ALUC_ADD;
    o_illegal_func = 1'b0;
    case (i_func)
      FN_ADD: o_aluc = ALUC_ADD;
      FN_SUB: o_aluc = ALUC_SUB;
      FN_AND: o_aluc = ALUC_AND;
      FN_OR:  o_aluc = ALUC_OR;
      FN_SLT: o_aluc = ALUC_SLT;
      default: o_illegal_func = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS sequencer: fetch/decode/execute/memory/write-back
// with a variable-latency memory handshake and an illegal-op trap.
module multicycle_ctrl
  import mips_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic [5:0] OP,
  input  logic [5:0] Func,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       MemReq,
  output logic       MemWrite,
  output logic       IorD,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic [1:0] PCSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       SEXT,
  output logic [3:0] ALUC,
  output logic       REGRT,
  output logic       Mem2Reg,
  output logic       WriteReg,
  output logic       InstrDone,
  output logic       Illegal
);

  state_t     r_state;
  state_t     w_next;
  ctrl_t      r_ctrl;
  logic [3:0] w_fn_aluc;
  logic       w_fn_ill;
  logic       w_run;
  logic       w_fetch;
  logic       w_memwr;
  logic       w_branch;
  logic       w_jump;

  alu_decoder u_alu_dec (
    .i_func         (Func),
    .o_aluc         (w_fn_aluc),
    .o_illegal_func (w_fn_ill)
  );

  // Next-state selection from state, latched IR fields and MemReady.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:  if (MemReady) w_next = S_DECODE;
      S_DECODE: begin
        case (OP)
          OP_R:    w_next = w_fn_ill ? S_TRAP : S_EXEC_R;
          OP_ADDI: w_next = S_EXEC_I;
          OP_LW:   w_next = S_ADDR;
          OP_SW:   w_next = S_ADDR;
          OP_BEQ:  w_next = S_BRANCH;
          OP_J:    w_next = S_JUMP;
          default: w_next = S_TRAP;
        endcase
      end
      S_EXEC_R: w_next = S_WB_R;
      S_EXEC_I: w_next = S_WB_I;
      S_ADDR:   w_next = (OP == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: if (MemReady) w_next = S_WB_MEM;
      S_MEM_WR: if (MemReady) w_next = S_FETCH;
      S_TRAP:   w_next = S_TRAP;
      default:  w_next = S_FETCH;
    endcase
  end

  // State and registered Moore outputs for the state being entered.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= S_FETCH;
      r_ctrl  <= ctrl_of(S_FETCH, ALUC_ADD);
    end else begin
      r_state <= w_next;
      r_ctrl  <= ctrl_of(w_next, w_fn_aluc);
    end
  end

  assign w_run    = ~Reset;
  assign w_fetch  = (r_state == S_FETCH);
  assign w_memwr  = (r_state == S_MEM_WR);
  assign w_branch = (r_state == S_BRANCH);
  assign w_jump   = (r_state == S_JUMP);

  assign MemReq   = w_run & r_ctrl.memreq;
  assign MemWrite = w_run & r_ctrl.memwrite;
  assign IorD     = w_run & r_ctrl.iord;
  assign PCSrc    = w_run ? r_ctrl.pcsrc : 2'b00;
  assign ALUSrcA  = w_run & r_ctrl.alusrca;
  assign ALUSrcB  = w_run ? r_ctrl.alusrcb : 2'b00;
  assign SEXT     = w_run & r_ctrl.sext;
  assign ALUC     = w_run ? r_ctrl.aluc : ALUC_ADD;
  assign REGRT    = w_run & r_ctrl.regrt;
  assign Mem2Reg  = w_run & r_ctrl.mem2reg;
  assign WriteReg = w_run & r_ctrl.writereg;
  assign Illegal  = w_run & r_ctrl.illegal;

  assign IRWrite = w_run & w_fetch & MemReady;
  assign PCWrite = w_run & ((w_fetch & MemReady) | w_jump |
                            (w_branch & Zero));
  assign InstrDone = w_run & (r_ctrl.done | (w_memwr & MemReady));

endmodule
